station_ctrl_fsm: RTL and testbench

STATION_CTRL_FSM -- requirements
Module: station_ctrl_fsm

---
 rtl/station_ctrl_fsm_if.sv | 29 ++
 rtl/station_ctrl_fsm.sv | 197 +++++++++++++++++++
 tb/tb_station_ctrl_fsm.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/station_ctrl_fsm_if.sv
// station_ctrl_fsm_if: mode, init and slot inputs plus enable outputs of the station controller
interface station_ctrl_fsm_if #(
  parameter int N_TX = 4,
  parameter int ID_W = 8
);
  logic [2:0]      mode_reg;
  logic [3:0]      slot_id;
  logic            flag_slot_start;
  logic [ID_W-1:0] id_slot;
  logic            ini_done;
  logic            ini_fail;
  logic            ini_start;
  logic            join_start;
  logic            flag_start_token;
  logic            process_en;
  logic [N_TX-1:0] tx_en;
  logic            down_en;
  logic            console_en;
  logic            fault;
  logic [2:0]      state_o;
  modport master (
    output mode_reg, slot_id, flag_slot_start, id_slot, ini_done, ini_fail,
    input  ini_start, join_start, flag_start_token, process_en, tx_en, down_en, console_en, fault, state_o
  );
  modport slave (
    input  mode_reg, slot_id, flag_slot_start, id_slot, ini_done, ini_fail,
    output ini_start, join_start, flag_start_token, process_en, tx_en, down_en, console_en, fault, state_o
  );
endinterface

// File: rtl/station_ctrl_fsm.sv
// station_ctrl_fsm: ring station bring-up sequencer (init, join, token sync, run, download, console, fault)
module station_ctrl_fsm #(
  parameter int N_TX          = 4,
  parameter int ID_W          = 8,
  parameter int INI_TIMEOUT   = 600000,
  parameter int TICK_DIV      = 600,
  parameter int SLOT_ID_A     = 14,
  parameter int SLOT_ID_B     = 13,
  parameter int JOIN_WAIT_A   = 30,
  parameter int JOIN_WAIT_B   = 70,
  parameter int JOIN_WAIT_DEF = 50,
  parameter int MAX_ID_SLOT   = 71,
  parameter int TOKEN_CYCLES  = 1,
  parameter int INI_RETRY     = 3
) (
  input logic clk,
  input logic rst,
  station_ctrl_fsm_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INIT, WAIT_JOIN, SYNC, RUN, DOWN, CONSOLE, FAULT} state_t;
  localparam int WMAX = JOIN_WAIT_A > JOIN_WAIT_B ? (JOIN_WAIT_A > JOIN_WAIT_DEF ? JOIN_WAIT_A : JOIN_WAIT_DEF)
                                                  : (JOIN_WAIT_B > JOIN_WAIT_DEF ? JOIN_WAIT_B : JOIN_WAIT_DEF);
  localparam int CW = $clog2(INI_TIMEOUT + 1);
  localparam int DW = $clog2(TICK_DIV + 1);
  localparam int TW = $clog2(WMAX + 1);
  localparam int KW = TOKEN_CYCLES > 0 ? $clog2(TOKEN_CYCLES + 1) : 1;
  localparam int RW = $clog2(INI_RETRY + 1);
  localparam logic [CW-1:0] TO    = CW'(INI_TIMEOUT);
  localparam logic [DW-1:0] DLAST = DW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TMAX  = TW'(WMAX);
  localparam logic [TW-1:0] WA    = TW'(JOIN_WAIT_A);
  localparam logic [TW-1:0] WB    = TW'(JOIN_WAIT_B);
  localparam logic [TW-1:0] WD    = TW'(JOIN_WAIT_DEF);
  localparam logic [KW-1:0] KMAX  = KW'(TOKEN_CYCLES);
  localparam logic [RW-1:0] RMAX  = RW'(INI_RETRY);
  localparam logic [N_TX-1:0] TX_MAIN = N_TX'(1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [KW-1:0] tok_q, tok_d;
  logic [RW-1:0] retry_q, retry_d;
  logic strobe_q, strobe_d, ini_start_q, ini_start_d, flag_q, flag_d, join_q, join_d;
  logic proc_q, proc_d, down_q, down_d, cons_q, cons_d, fault_q, fault_d;
  logic [N_TX-1:0] tx_q, tx_d;
  logic [TW-1:0] wait_w;
  logic [RW-1:0] retry_inc;
  logic m_down, ifail, to_down, to_idle;
  assign wait_w    = bus.slot_id == 4'(SLOT_ID_A) ? WA : bus.slot_id == 4'(SLOT_ID_B) ? WB : WD;
  assign retry_inc = retry_q + 1'b1;
  assign m_down    = bus.mode_reg == 3'b100;
  assign ifail     = cnt_q >= TO || (bus.ini_fail && !bus.ini_done);
  // next-state, counter and registered-output decode; shared exits into DOWN/IDLE applied after the case
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    div_d = div_q;
    tick_d = tick_q;
    tok_d = tok_q;
    retry_d = retry_q;
    strobe_d = state_q == SYNC && bus.flag_slot_start && bus.id_slot == ID_W'(MAX_ID_SLOT);
    ini_start_d = 1'b0;
    flag_d = 1'b0;
    join_d = join_q;
    proc_d = proc_q;
    tx_d = tx_q;
    down_d = down_q;
    cons_d = cons_q;
    fault_d = fault_q;
    to_down = 1'b0;
    to_idle = 1'b0;
    case (state_q)
      IDLE: begin
        to_down = m_down;
        if (!m_down) begin
          state_d = INIT;
          ini_start_d = 1'b1;
          cnt_d = '0;
        end
      end
      INIT: begin
        cnt_d = cnt_q == TO ? cnt_q : cnt_q + 1'b1;
        if (m_down) to_down = 1'b1;
        else if (ifail) begin
          retry_d = retry_inc;
          state_d = retry_inc >= RMAX ? FAULT : IDLE;
          fault_d = retry_inc >= RMAX;
          tx_d = '0;
          proc_d = 1'b0;
        end else if (bus.ini_done) begin
          retry_d = '0;
          state_d = WAIT_JOIN;
          tx_d = ~TX_MAIN;
          div_d = '0;
          tick_d = '0;
        end
      end
      WAIT_JOIN: begin
        div_d = div_q == DLAST ? '0 : div_q + 1'b1;
        tick_d = (div_q == DLAST && tick_q != TMAX) ? tick_q + 1'b1 : tick_q;
        if (tick_q >= wait_w || bus.flag_slot_start) begin
          state_d = SYNC;
          join_d = tick_q < wait_w;
          flag_d = tick_q >= wait_w;
          proc_d = 1'b1;
          tok_d = '0;
        end
      end
      SYNC: begin
        tx_d = tx_q | TX_MAIN;
        tok_d = (strobe_q && tok_q != KMAX) ? tok_q + 1'b1 : tok_q;
        if (tok_q >= KMAX) begin
          state_d = RUN;
          join_d = 1'b1;
        end
      end
      RUN: begin
        to_down = m_down;
        if (bus.mode_reg == 3'b010) begin
          state_d = CONSOLE;
          proc_d = 1'b0;
          cons_d = 1'b1;
        end
      end
      CONSOLE: begin
        to_down = m_down;
        to_idle = bus.mode_reg == 3'b001;
      end
      DOWN: begin
        to_idle = !m_down;
        retry_d = m_down ? retry_q : '0;
      end
      FAULT: to_down = m_down;
      default: state_d = IDLE;
    endcase
    if (to_down) begin
      state_d = DOWN;
      down_d = 1'b1;
      tx_d = TX_MAIN;
      proc_d = 1'b0;
      cons_d = 1'b0;
      fault_d = 1'b0;
    end
    if (to_idle) begin
      state_d = IDLE;
      down_d = 1'b0;
      cons_d = 1'b0;
      proc_d = 1'b0;
      tx_d = '0;
    end
  end
  // state, counters and outputs; low rst wins over every input
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= '0;
      tick_q <= '0;
      tok_q <= '0;
      retry_q <= '0;
      strobe_q <= 1'b0;
      ini_start_q <= 1'b0;
      flag_q <= 1'b0;
      join_q <= 1'b1;
      proc_q <= 1'b0;
      tx_q <= '0;
      down_q <= 1'b0;
      cons_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      tick_q <= tick_d;
      tok_q <= tok_d;
      retry_q <= retry_d;
      strobe_q <= strobe_d;
      ini_start_q <= ini_start_d;
      flag_q <= flag_d;
      join_q <= join_d;
      proc_q <= proc_d;
      tx_q <= tx_d;
      down_q <= down_d;
      cons_q <= cons_d;
      fault_q <= fault_d;
    end
  end
  assign bus.state_o          = state_q;
  assign bus.ini_start        = ini_start_q;
  assign bus.flag_start_token = flag_q;
  assign bus.join_start       = join_q;
  assign bus.process_en       = proc_q;
  assign bus.tx_en            = tx_q;
  assign bus.down_en          = down_q;
  assign bus.console_en       = cons_q;
  assign bus.fault            = fault_q;
endmodule

// File: tb/tb_station_ctrl_fsm.sv
// tb_station_ctrl_fsm: randomized bring-up sequences checked against timing derived from the station rules
module tb_station_ctrl_fsm;
  localparam int TO = 40, TD = 4, RETRY = 3, MAXS = 71;
  localparam logic [2:0] S_IDLE = 0, S_INIT = 1, S_WJ = 2, S_SYNC = 3, S_RUN = 4, S_DOWN = 5, S_CONS = 6, S_FAULT = 7;
  logic clk = 1'b0, rst = 1'b0;
  int total = 0, bad = 0;
  station_ctrl_fsm_if #(.N_TX(4), .ID_W(8)) bus ();
  station_ctrl_fsm #(
    .N_TX(4), .ID_W(8), .INI_TIMEOUT(TO), .TICK_DIV(TD), .SLOT_ID_A(14), .SLOT_ID_B(13),
    .JOIN_WAIT_A(3), .JOIN_WAIT_B(7), .JOIN_WAIT_DEF(5), .MAX_ID_SLOT(MAXS), .TOKEN_CYCLES(1), .INI_RETRY(RETRY)
  ) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic int jw(input int s);
    return s == 14 ? 3 : s == 13 ? 7 : 5;
  endfunction
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_st(input logic [2:0] st, input int lim, output int n);
    n = 0;
    while (bus.state_o !== st && n < lim) begin
      step(1);
      n++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, d, k, w, slot, m, lat;
    bus.mode_reg = 3'b001; bus.slot_id = 0; bus.flag_slot_start = 0; bus.id_slot = 0;
    bus.ini_done = 0; bus.ini_fail = 0;
    step(2);
    chk("rst_state", bus.state_o, S_IDLE);
    chk("rst_join", bus.join_start, 1);
    chk("rst_outs", {bus.ini_start, bus.flag_start_token, bus.process_en, bus.tx_en, bus.down_en, bus.console_en, bus.fault}, 0);
    bus.mode_reg = 3'b011; rst = 1'b1;
    step(1);
    chk("nonhot_init", bus.state_o, S_INIT);
    chk("ini_pulse", bus.ini_start, 1);
    bus.mode_reg = 3'b001;
    step(1);
    chk("ini_pulse_end", bus.ini_start, 0);
    for (int i = 0; i < 6; i++) begin
      m = i < 3 ? i : $urandom_range(0, 2);
      d = $urandom_range(1, 8);
      case ($urandom_range(0, 2))
        0: slot = 14;
        1: slot = 13;
        default: slot = $urandom_range(0, 12);
      endcase
      bus.slot_id = 4'(slot);
      w = jw(slot);
      step(d);
      bus.ini_done = 1;
      step(1);
      bus.ini_done = 0;
      chk("wj_state", bus.state_o, S_WJ);
      chk("wj_tx", bus.tx_en, 4'b1110);
      if (m == 0) begin
        wait_st(S_SYNC, 400, n);
        chk("expiry_lat", n, w * TD + 1);
        k = w;
      end else begin
        k = m == 2 ? w : $urandom_range(0, w - 1);
        step(k * TD);
        bus.flag_slot_start = 1;
        step(1);
        bus.flag_slot_start = 0;
        wait_st(S_SYNC, 400, n);
        lat = k * TD + 1 + n;
        chk("slot_lat", lat, k * TD + 1);
      end
      chk("sync_join", bus.join_start, k < w);
      chk("sync_token", bus.flag_start_token, k >= w);
      chk("sync_proc", bus.process_en, 1);
      chk("sync_tx0", bus.tx_en, 4'b1110);
      step(1);
      chk("token_end", bus.flag_start_token, 0);
      chk("sync_tx1", bus.tx_en, 4'b1111);
      bus.flag_slot_start = 1; bus.id_slot = MAXS - 1;
      step(1);
      bus.flag_slot_start = 0; bus.id_slot = 0;
      step(3);
      chk("sync_hold", bus.state_o, S_SYNC);
      bus.flag_slot_start = 1; bus.id_slot = MAXS;
      step(1);
      bus.flag_slot_start = 0; bus.id_slot = 0;
      wait_st(S_RUN, 20, n);
      chk("run_lat", n + 1, 3);
      chk("run_join", bus.join_start, 1);
      bus.mode_reg = 3'b010;
      step(1);
      chk("cons_state", {bus.state_o, bus.process_en, bus.console_en}, {S_CONS, 2'b01});
      chk("cons_tx", bus.tx_en, 4'b1111);
      bus.mode_reg = 3'b001;
      step(1);
      chk("cons_exit", {bus.state_o, bus.console_en}, {S_IDLE, 1'b0});
      step(1);
      chk("reinit", {bus.state_o, bus.ini_start}, {S_INIT, 1'b1});
    end
    for (int r = 1; r <= RETRY; r++) begin
      bus.ini_fail = 1;
      step(1);
      bus.ini_fail = 0;
      chk("fail_state", bus.state_o, r == RETRY ? S_FAULT : S_IDLE);
      if (r < RETRY) begin
        step(1);
        chk("fail_reinit", {bus.state_o, bus.ini_start}, {S_INIT, 1'b1});
      end
    end
    chk("fault_outs", {bus.fault, bus.tx_en, bus.process_en, bus.down_en}, 7'b1000000);
    step(3);
    chk("fault_hold", bus.state_o, S_FAULT);
    bus.mode_reg = 3'b100;
    step(1);
    chk("down_outs", {bus.state_o, bus.fault, bus.down_en, bus.tx_en, bus.process_en}, {S_DOWN, 1'b0, 1'b1, 4'b0001, 1'b0});
    bus.mode_reg = 3'b001;
    step(1);
    chk("down_exit", {bus.state_o, bus.down_en, bus.tx_en}, {S_IDLE, 1'b0, 4'b0000});
    step(1);
    wait_st(S_IDLE, TO + 10, n);
    chk("timeout_lat", n, TO + 1);
    step(1);
    step(TO);
    bus.ini_done = 1;
    step(1);
    bus.ini_done = 0;
    chk("timeout_wins", bus.state_o, S_IDLE);
    step(1);
    bus.ini_fail = 1;
    step(1);
    bus.ini_fail = 0;
    chk("third_fail", bus.state_o, S_FAULT);
    bus.mode_reg = 3'b100;
    step(1);
    bus.mode_reg = 3'b001;
    step(2);
    chk("clean_init", bus.state_o, S_INIT);
    step(TO - 1);
    bus.ini_done = 1;
    step(1);
    bus.ini_done = 0;
    chk("done_edge", bus.state_o, S_WJ);
    bus.flag_slot_start = 1;
    step(1);
    bus.flag_slot_start = 0;
    chk("flag_sync", {bus.state_o, bus.join_start}, {S_SYNC, 1'b1});
    rst = 0; bus.flag_slot_start = 1; bus.id_slot = MAXS;
    step(1);
    rst = 1; bus.flag_slot_start = 0; bus.id_slot = 0;
    chk("mid_rst_state", {bus.state_o, bus.join_start}, {S_IDLE, 1'b1});
    chk("mid_rst_outs", {bus.ini_start, bus.flag_start_token, bus.process_en, bus.tx_en, bus.down_en, bus.console_en, bus.fault}, 0);
    step(1);
    chk("post_rst_init", bus.state_o, S_INIT);
    bus.mode_reg = 3'b100; bus.ini_done = 1;
    step(1);
    bus.ini_done = 0;
    chk("init_abort", bus.state_o, S_DOWN);
    bus.mode_reg = 3'b001;
    step(1);
    bus.mode_reg = 3'b100;
    step(1);
    chk("idle_down", bus.state_o, S_DOWN);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
